// File: rtl/fact_seq_engine_pkg.sv
// Shared definitions for the factorial sequencer: FSM state encoding and type.
package fact_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_NEXT = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_MUL  = ST_MUL,
    S_NEXT = ST_NEXT,
    S_DONE = ST_DONE
  } state_t;

endpackage

// File: rtl/fact_seq_engine_if.sv
// Host-side handshake bundle of the factorial sequencer (Start/A in, Busy/Done/Result/Ovf out).
interface fact_seq_engine_if #(
  parameter int IN_W  = 4,
  parameter int OUT_W = 16
);

  logic             Start;
  logic [IN_W-1:0]  A;
  logic             Busy;
  logic             Done;
  logic [OUT_W-1:0] Result;
  logic             Ovf;

  // Host drives the request, observes status and result.
  modport master (
    output Start, A,
    input  Busy, Done, Result, Ovf
  );

  // Engine consumes the request, drives status and result.
  modport slave (
    input  Start, A,
    output Busy, Done, Result, Ovf
  );

endinterface

// File: rtl/fact_seq_engine_mul.sv
// Sequential shift-add multiplier: one multiplier bit per cycle, LSB first.
// The start cycle itself processes bit 0 using the live inputs, so the full
// product is presented on product_o during the IN_W-th cycle (flagged by last_o).
module seq_shift_add_mul #(
  parameter int IN_W  = 4,
  parameter int OUT_W = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_i,
  input  logic [OUT_W-1:0]      mcand_i,
  input  logic [IN_W-1:0]       mplier_i,
  output logic [OUT_W+IN_W-1:0] product_o,
  output logic                  last_o
);

  localparam int PW = OUT_W + IN_W;
  localparam int BW = (IN_W > 1) ? $clog2(IN_W) : 1;

  logic             active_q;
  logic [BW-1:0]    bit_q;
  logic [PW-1:0]    partial_q;
  logic [OUT_W-1:0] mcand_q;
  logic [IN_W-1:0]  mplier_q;

  logic [BW-1:0]    cur_bit;
  logic [OUT_W-1:0] cur_mcand;
  logic [IN_W-1:0]  cur_mplier;
  logic [PW-1:0]    cur_partial;
  logic [PW-1:0]    addend;
  logic             running;

  // Select live operands on the start cycle, latched copies afterwards.
  always_comb begin
    running     = start_i | active_q;
    cur_bit     = start_i ? '0 : bit_q;
    cur_mcand   = start_i ? mcand_i : mcand_q;
    cur_mplier  = start_i ? mplier_i : mplier_q;
    cur_partial = start_i ? '0 : partial_q;
    addend      = cur_mplier[cur_bit] ? (PW'(cur_mcand) << cur_bit) : '0;
    product_o   = cur_partial + addend;
    last_o      = running && (cur_bit == BW'(IN_W - 1));
  end

  // Accumulate one shifted partial product per cycle until the last bit.
  always_ff @(posedge clk) begin
    if (!reset) begin
      active_q  <= 1'b0;
      bit_q     <= '0;
      partial_q <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
    end else begin
      if (start_i) begin
        mcand_q  <= mcand_i;
        mplier_q <= mplier_i;
      end
      if (running) begin
        partial_q <= product_o;
        bit_q     <= cur_bit + BW'(1);
        active_q  <= !last_o;
      end
    end
  end

endmodule

// File: rtl/fact_seq_engine.sv
// Factorial sequencer: latches A on Start and computes A! mod 2^OUT_W by
// multiplying the accumulator by A, A-1, ..., 2 with a sequential multiplier.
module fact_seq_engine
  import fact_pkg::*;
#(
  parameter int IN_W  = 4,
  parameter int OUT_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  fact_seq_engine_if.slave    bus
);

  localparam int PW = OUT_W + IN_W;

  state_t           state_q;
  logic [OUT_W-1:0] acc_q;
  logic [IN_W-1:0]  cnt_q;
  logic [IN_W-1:0]  cnt_d;
  logic             busy_q;
  logic             done_q;
  logic [OUT_W-1:0] result_q;
  logic             ovf_q;
  logic             mul_start_q;

  logic [PW-1:0]    mul_product;
  logic             mul_last;

  seq_shift_add_mul #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_mul (
    .clk       (clk),
    .reset     (reset),
    .start_i   (mul_start_q),
    .mcand_i   (acc_q),
    .mplier_i  (cnt_q),
    .product_o (mul_product),
    .last_o    (mul_last)
  );

  // Next factor after a multiply completes.
  always_comb begin
    cnt_d = cnt_q - IN_W'(1);
  end

  // Control FSM; Done/Result are loaded on entry to DONE so they are visible in that cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      result_q    <= '0;
      ovf_q       <= 1'b0;
      mul_start_q <= 1'b0;
    end else begin
      mul_start_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.Start) begin
            acc_q  <= OUT_W'(1);
            cnt_q  <= bus.A;
            ovf_q  <= 1'b0;
            busy_q <= 1'b1;
            if (bus.A > IN_W'(1)) begin
              state_q     <= S_MUL;
              mul_start_q <= 1'b1;
            end else begin
              // 0! and 1! need no multiplication.
              state_q  <= S_DONE;
              done_q   <= 1'b1;
              result_q <= OUT_W'(1);
            end
          end
        end
        S_MUL: begin
          if (mul_last) begin
            acc_q   <= mul_product[OUT_W-1:0];
            ovf_q   <= ovf_q | (|mul_product[PW-1:OUT_W]);
            state_q <= S_NEXT;
          end
        end
        S_NEXT: begin
          cnt_q <= cnt_d;
          if (cnt_d == IN_W'(1)) begin
            state_q  <= S_DONE;
            done_q   <= 1'b1;
            result_q <= acc_q;
          end else begin
            state_q     <= S_MUL;
            mul_start_q <= 1'b1;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Drive the host bundle straight from registers.
  always_comb begin
    bus.Busy   = busy_q;
    bus.Done   = done_q;
    bus.Result = result_q;
    bus.Ovf    = ovf_q;
  end

endmodule

// File: tb/tb_fact_seq_engine.sv
// Self-checking bench for fact_seq_engine (IN_W=4, OUT_W=16).
module tb_fact_seq_engine;

  localparam int IN_W  = 4;
  localparam int OUT_W = 16;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_fail;

  fact_seq_engine_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

  fact_seq_engine #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: true factorial in wide arithmetic.
  function automatic longint unsigned fact_full(input int a);
    longint unsigned p;
    p = 1;
    for (int k = 2; k <= a; k++) p = p * longint'(k);
    return p;
  endfunction

  function automatic logic [31:0] ref_result(input int a);
    return 32'(fact_full(a) % 64'd65536);
  endfunction

  // Partial products grow monotonically, so an intermediate overflow happens iff A! itself overflows.
  function automatic logic [31:0] ref_ovf(input int a);
    return (fact_full(a) > 64'd65535) ? 32'd1 : 32'd0;
  endfunction

  function automatic logic [31:0] ref_latency(input int a);
    return (a < 2) ? 32'd1 : 32'((a - 1) * (IN_W + 1) + 1);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Count cycles until Done, bounded; start_n is the cycle index we are currently in.
  task automatic wait_done(input int start_n, output int lat);
    lat = start_n;
    while (bus.Done !== 1'b1 && lat < 500) begin
      step();
      lat++;
    end
    check("done_seen", 32'(bus.Done), 32'd1);
  endtask

  // Launch one operation from IDLE and check it end to end.
  task automatic run_op(input int a);
    int lat;
    bus.A     = IN_W'(a);
    bus.Start = 1'b1;
    step();
    bus.Start = 1'b0;
    wait_done(1, lat);
    check($sformatf("lat_A%0d", a), 32'(lat), ref_latency(a));
    check($sformatf("result_A%0d", a), 32'(bus.Result), ref_result(a));
    check($sformatf("ovf_A%0d", a), 32'(bus.Ovf), ref_ovf(a));
    check($sformatf("busy_in_done_A%0d", a), 32'(bus.Busy), 32'd1);
    step();
    check($sformatf("done_pulse_A%0d", a), 32'(bus.Done), 32'd0);
    check($sformatf("idle_busy_A%0d", a), 32'(bus.Busy), 32'd0);
    $display("op A=%0d lat=%0d Result=%0d Ovf=%0d", a, lat, bus.Result, bus.Ovf);
  endtask

  initial begin
    int lat;
    int dn;
    int a;
    n_cmp     = 0;
    n_fail    = 0;
    reset     = 1'b0;
    bus.Start = 1'b1;
    bus.A     = IN_W'(5);

    // Reset with Start asserted must not launch anything.
    step();
    step();
    check("rst_busy", 32'(bus.Busy), 32'd0);
    check("rst_done", 32'(bus.Done), 32'd0);
    check("rst_result", 32'(bus.Result), 32'd0);
    check("rst_ovf", 32'(bus.Ovf), 32'd0);
    bus.Start = 1'b0;
    reset     = 1'b1;
    step();
    check("post_rst_busy", 32'(bus.Busy), 32'd0);
    $display("reset checked");

    // Directed operands including bypass and overflow boundaries.
    run_op(0);
    run_op(1);
    run_op(5);
    run_op(3);
    run_op(8);
    run_op(9);
    run_op(15);

    // Random operands.
    for (int i = 0; i < 6; i++) begin
      a = int'($urandom_range(15, 0));
      run_op(a);
    end

    // Start pulses and A changes while Busy are ignored.
    bus.A     = IN_W'(6);
    bus.Start = 1'b1;
    step();
    bus.Start = 1'b0;
    repeat (3) step();
    bus.Start = 1'b1;
    bus.A     = IN_W'(3);
    step();
    bus.A     = IN_W'(9);
    step();
    bus.Start = 1'b0;
    bus.A     = IN_W'(2);
    wait_done(6, lat);
    check("ign_lat", 32'(lat), ref_latency(6));
    check("ign_result", 32'(bus.Result), ref_result(6));
    check("ign_ovf", 32'(bus.Ovf), ref_ovf(6));
    step();
    check("ign_idle", 32'(bus.Busy), 32'd0);
    step();
    check("ign_no_restart", 32'(bus.Busy), 32'd0);
    $display("busy-ignore A=6 lat=%0d Result=%0d", lat, bus.Result);

    // Start held high: back-to-back runs, one Done pulse each.
    bus.A     = IN_W'(3);
    bus.Start = 1'b1;
    step();
    for (int r = 0; r < 2; r++) begin
      wait_done(1, lat);
      check($sformatf("b2b_lat%0d", r), 32'(lat), ref_latency(3));
      check($sformatf("b2b_result%0d", r), 32'(bus.Result), ref_result(3));
      step();
      check($sformatf("b2b_single_done%0d", r), 32'(bus.Done), 32'd0);
      check($sformatf("b2b_idle%0d", r), 32'(bus.Busy), 32'd0);
      if (r == 1) bus.Start = 1'b0;
      step();
      check($sformatf("b2b_reaccept%0d", r), 32'(bus.Busy), (r == 0) ? 32'd1 : 32'd0);
      $display("back-to-back run %0d lat=%0d Result=%0d", r, lat, bus.Result);
    end

    // Reset in the middle of a multiply aborts with no Done.
    bus.A     = IN_W'(7);
    bus.Start = 1'b1;
    step();
    bus.Start = 1'b0;
    step();
    step();
    reset = 1'b0;
    step();
    check("abort_busy", 32'(bus.Busy), 32'd0);
    check("abort_done", 32'(bus.Done), 32'd0);
    check("abort_result", 32'(bus.Result), 32'd0);
    reset = 1'b1;
    dn    = 0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (bus.Done === 1'b1) dn++;
    end
    check("abort_no_done", 32'(dn), 32'd0);
    $display("mid-run reset A=7 Done pulses after abort=%0d", dn);
    run_op(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
